// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types and constants for the ALU serial command path.
//               Holds the frame type, opcode set, error flag bit positions,
//               the CRC4 polynomial and small helper functions used by the
//               command receiver.
// Ports       : none (package)
// Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

  // Frame type carried in the bit after the start bit.
  typedef enum logic {
    CMD_DATA = 1'b0,
    CMD_CTL  = 1'b1
  } cmd_t;

  // Legal ALU opcodes; every other 3-bit value is rejected.
  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } op_t;

  // Bit positions inside err_flags.
  localparam int unsigned ERR_DATA = 2;
  localparam int unsigned ERR_CRC  = 1;
  localparam int unsigned ERR_OP   = 0;

  localparam logic [2:0] FLAG_DATA = 3'b001 << ERR_DATA;
  localparam logic [2:0] FLAG_CRC  = 3'b001 << ERR_CRC;
  localparam logic [2:0] FLAG_OP   = 3'b001 << ERR_OP;

  // x^4 + x + 1 with the implicit x^4 term dropped.
  localparam logic [3:0] CRC4_POLY = 4'b0011;

  // Frame geometry and packet length.
  localparam int unsigned FRAME_DATA_BITS = 8;
  localparam logic [3:0]  PKT_DATA_BYTES  = 4'd8;
  localparam logic [3:0]  PKT_CNT_MAX     = 4'd9;

  // One bit-serial CRC4 step, MSB-first.
  function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic d);
    logic fb;
    fb = crc[3] ^ d;
    return {crc[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'b0000);
  endfunction

  function automatic logic op_is_legal(input logic [2:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : alu_frame_rx
// Description : Bit-level receiver for 11-bit frames on the serial command
//               line: start(0), type, d[7]..d[0], stop(1), one bit per clk.
// Ports       : clk          - system clock, all sampling on posedge
//               rst_n        - asynchronous active-low reset
//               sin          - serial input, idle high
//               frame_valid  - strobe: stop bit sampled high on this edge
//               frame_err    - strobe: stop bit sampled low on this edge
//               frame_type   - type bit of the frame in flight (1 = CTL)
//               frame_byte   - assembled data byte of the frame in flight
//               bit_valid    - strobe: sin is a data bit of a DATA frame
//               bit_data     - the data bit accompanying bit_valid
// Revision    : 1.0  initial release
// ============================================================================
module alu_frame_rx
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sin,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       frame_type,
  output logic [7:0] frame_byte,
  output logic       bit_valid,
  output logic       bit_data
);

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_TYPE = 2'd1,
    F_DATA = 2'd2,
    F_STOP = 2'd3
  } frame_state_t;

  frame_state_t r_state;
  logic [2:0]   r_bit_cnt;
  logic         r_type;
  logic [7:0]   r_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= F_IDLE;
      r_bit_cnt <= 3'd0;
      r_type    <= 1'b0;
      r_byte    <= 8'h00;
    end else begin
      case (r_state)
        F_IDLE: begin
          if (!sin) begin
            r_state <= F_TYPE;
          end
        end
        F_TYPE: begin
          r_type    <= sin;
          r_bit_cnt <= 3'd0;
          r_state   <= F_DATA;
        end
        F_DATA: begin
          r_byte    <= {r_byte[6:0], sin};
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'(FRAME_DATA_BITS - 1)) begin
            r_state <= F_STOP;
          end
        end
        F_STOP: begin
          // Always back to IDLE so a start bit on the very next cycle is seen.
          r_state <= F_IDLE;
        end
        default: begin
          r_state <= F_IDLE;
        end
      endcase
    end
  end

  // The strobes are decoded from the registered state and the live sample so
  // the packet logic can act on the same edge that samples the stop bit;
  // that keeps the report one cycle after the final stop sample.
  assign frame_valid = (r_state == F_STOP) &&  sin;
  assign frame_err   = (r_state == F_STOP) && !sin;
  assign frame_type  = r_type;
  assign frame_byte  = r_byte;

  // Only DATA-frame payload feeds the running CRC; CTL bits are folded in
  // separately once the whole CTL byte is known.
  assign bit_valid   = (r_state == F_DATA) && (r_type == CMD_DATA);
  assign bit_data    = sin;

endmodule : alu_frame_rx
`default_nettype wire

// File: rtl/alu_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_rx
// Description : Serial command receiver for the ALU. Collects 8 DATA bytes
//               and one CTL byte, checks framing, length, CRC4 and opcode,
//               then pulses either a validated command or an error code.
// Ports       : clk        - system clock
//               rst_n      - asynchronous active-low reset
//               sin        - serial command line, idle high
//               cmd_valid  - one-cycle pulse, cmd_a/cmd_b/cmd_op valid
//               cmd_a      - operand A (last four DATA bytes)
//               cmd_b      - operand B (first four DATA bytes)
//               cmd_op     - opcode from CTL[6:4]
//               err_valid  - one-cycle pulse, err_flags valid
//               err_flags  - {ERR_DATA, ERR_CRC, ERR_OP}, one-hot on error
// Revision    : 1.0  initial release
// ============================================================================
module alu_cmd_rx
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic        cmd_valid,
  output logic [31:0] cmd_a,
  output logic [31:0] cmd_b,
  output logic [2:0]  cmd_op,
  output logic        err_valid,
  output logic [2:0]  err_flags
);

  // --------------------------------------------------------------------------
  // Frame receiver
  // --------------------------------------------------------------------------
  logic       w_frame_valid;
  logic       w_frame_err;
  logic       w_frame_type;
  logic [7:0] w_frame_byte;
  logic       w_bit_valid;
  logic       w_bit_data;

  alu_frame_rx u_frame_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .sin         (sin),
    .frame_valid (w_frame_valid),
    .frame_err   (w_frame_err),
    .frame_type  (w_frame_type),
    .frame_byte  (w_frame_byte),
    .bit_valid   (w_bit_valid),
    .bit_data    (w_bit_data)
  );

  // --------------------------------------------------------------------------
  // Packet state
  // --------------------------------------------------------------------------
  // P_CHECK is the cycle in which the report pulse is on the outputs; the
  // checks themselves are evaluated on the edge that accepts the CTL frame.
  typedef enum logic [1:0] {
    P_IDLE    = 2'd0,
    P_COLLECT = 2'd1,
    P_CHECK   = 2'd2
  } pkt_state_t;

  pkt_state_t  r_state;
  logic [3:0]  r_byte_cnt;
  logic [3:0]  r_crc;
  logic [63:0] r_shift;

  logic       w_ctl_done;
  logic       w_data_done;
  logic [2:0] w_op;
  logic [3:0] w_crc_final;
  logic       w_err_data;
  logic       w_err_crc;
  logic       w_err_op;

  assign w_ctl_done  = w_frame_valid && (w_frame_type == CMD_CTL);
  assign w_data_done = w_frame_valid && (w_frame_type == CMD_DATA);
  assign w_op        = w_frame_byte[6:4];

  // Fold the constant-1 marker and the three opcode bits (MSB first) into
  // the CRC accumulated over the 64 operand bits.
  assign w_crc_final = crc4_step(crc4_step(crc4_step(crc4_step(
                         r_crc, 1'b1), w_op[2]), w_op[1]), w_op[0]);

  assign w_err_data  = (r_byte_cnt != PKT_DATA_BYTES) || w_frame_byte[7];
  assign w_err_crc   = (w_frame_byte[3:0] != w_crc_final);
  assign w_err_op    = !op_is_legal(w_op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= P_IDLE;
      r_byte_cnt <= 4'd0;
      r_crc      <= 4'd0;
      r_shift    <= 64'd0;
      cmd_valid  <= 1'b0;
      cmd_a      <= 32'd0;
      cmd_b      <= 32'd0;
      cmd_op     <= 3'd0;
      err_valid  <= 1'b0;
      err_flags  <= 3'd0;
    end else begin
      cmd_valid <= 1'b0;
      err_valid <= 1'b0;

      // Bit strobes only occur inside a frame, never on a stop-bit edge, so
      // the clears below cannot collide with an accumulate.
      if (w_bit_valid) begin
        r_crc <= crc4_step(r_crc, w_bit_data);
      end

      if (w_frame_err) begin
        // Broken framing discards the packet whatever its progress.
        err_valid  <= 1'b1;
        err_flags  <= FLAG_DATA;
        r_byte_cnt <= 4'd0;
        r_crc      <= 4'd0;
        r_state    <= P_CHECK;
      end else if (w_ctl_done) begin
        r_byte_cnt <= 4'd0;
        r_crc      <= 4'd0;
        r_state    <= P_CHECK;
        if (w_err_data) begin
          err_valid <= 1'b1;
          err_flags <= FLAG_DATA;
        end else if (w_err_crc) begin
          err_valid <= 1'b1;
          err_flags <= FLAG_CRC;
        end else if (w_err_op) begin
          err_valid <= 1'b1;
          err_flags <= FLAG_OP;
        end else begin
          cmd_valid <= 1'b1;
          cmd_b     <= r_shift[63:32];
          cmd_a     <= r_shift[31:0];
          cmd_op    <= w_op;
        end
      end else if (w_data_done) begin
        r_shift <= {r_shift[55:0], w_frame_byte};
        // Saturating count still flags over-long packets without wrapping.
        if (r_byte_cnt != PKT_CNT_MAX) begin
          r_byte_cnt <= r_byte_cnt + 4'd1;
        end
        r_state <= P_COLLECT;
      end else if (r_state == P_CHECK) begin
        r_state <= P_IDLE;
      end
    end
  end

endmodule : alu_cmd_rx
`default_nettype wire

// File: tb/tb_alu_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_rx
// Description : Self-checking bench for alu_cmd_rx. Directed packets from the
//               test plan followed by randomized packets; expected reports
//               come from a packet-level reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_cmd_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sin = 1'b1;
  logic        cmd_valid;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [2:0]  cmd_op;
  logic        err_valid;
  logic [2:0]  err_flags;

  alu_cmd_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .cmd_valid (cmd_valid),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
    .err_valid (err_valid),
    .err_flags (err_flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  typedef struct {
    bit         is_cmd;
    logic [2:0] flags;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0] op;
    int         at_edge;
  } rep_t;

  rep_t        exp_q[$];
  logic [7:0]  pkt_q[$];
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic [2:0]  m_op = '0;
  logic [2:0]  m_flags = '0;

  // CRC as polynomial remainder: msg(x) * x^4 mod (x^4 + x + 1).
  function automatic logic [3:0] ref_crc(input logic [67:0] msg);
    logic [71:0] r;
    r = {msg, 4'b0000};
    for (int i = 71; i >= 4; i--) begin
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    end
    return r[3:0];
  endfunction

  task automatic push_rep(input bit is_cmd, input logic [2:0] flags,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input int at_edge);
    rep_t e;
    e.is_cmd = is_cmd; e.flags = flags; e.a = a; e.b = b; e.op = op;
    e.at_edge = at_edge;
    exp_q.push_back(e);
  endtask

  task automatic model_frame(input bit is_ctl, input logic [7:0] d,
                             input bit stop_ok, input int at_edge);
    logic [31:0] a, b;
    logic [2:0]  op;
    if (!stop_ok) begin
      push_rep(1'b0, 3'b100, '0, '0, '0, at_edge);
      pkt_q.delete();
    end else if (!is_ctl) begin
      pkt_q.push_back(d);
    end else begin
      op = d[6:4];
      if (pkt_q.size() != 8 || d[7]) begin
        push_rep(1'b0, 3'b100, '0, '0, '0, at_edge);
      end else begin
        b = {pkt_q[0], pkt_q[1], pkt_q[2], pkt_q[3]};
        a = {pkt_q[4], pkt_q[5], pkt_q[6], pkt_q[7]};
        if (d[3:0] != ref_crc({b, a, 1'b1, op}))
          push_rep(1'b0, 3'b010, '0, '0, '0, at_edge);
        else if (!(op == 3'b000 || op == 3'b001 || op == 3'b100 || op == 3'b101))
          push_rep(1'b0, 3'b001, '0, '0, '0, at_edge);
        else
          push_rep(1'b1, 3'b000, a, b, op, at_edge);
      end
      pkt_q.delete();
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor: every pulse must match the head of the expected queue.
  // --------------------------------------------------------------------------
  rep_t mon_r;
  always @(negedge clk) begin
    if (cmd_valid || err_valid) begin
      chk("pulse_exclusive", 64'(cmd_valid & err_valid), 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 64'({cmd_valid, err_valid}), 64'd0);
      end else begin
        mon_r = exp_q.pop_front();
        chk("report_cycle", 64'(cyc + 1), 64'(mon_r.at_edge));
        chk("report_kind", 64'(cmd_valid), 64'(mon_r.is_cmd));
        if (mon_r.is_cmd) begin
          chk("cmd_a", 64'(cmd_a), 64'(mon_r.a));
          chk("cmd_b", 64'(cmd_b), 64'(mon_r.b));
          chk("cmd_op", 64'(cmd_op), 64'(mon_r.op));
          chk("err_flags_hold", 64'(err_flags), 64'(m_flags));
          m_a = mon_r.a; m_b = mon_r.b; m_op = mon_r.op;
        end else begin
          chk("err_flags", 64'(err_flags), 64'(mon_r.flags));
          chk("cmd_hold", {cmd_a, cmd_b}, {m_a, m_b});
          chk("cmd_op_hold", 64'(cmd_op), 64'(m_op));
          m_flags = mon_r.flags;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver
  // --------------------------------------------------------------------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sin = 1'b1;
    end
  endtask

  // abort_at >= 0 asserts reset instead of driving that bit of the frame.
  task automatic send_frame(input bit is_ctl, input logic [7:0] d,
                            input bit stop_ok = 1'b1, input int gap = 0,
                            input int abort_at = -1);
    logic [10:0] fr;
    fr = {1'b0, is_ctl, d, stop_ok};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i == abort_at) begin
        rst_n = 1'b0;
        sin   = 1'b1;
        exp_q.delete();
        pkt_q.delete();
        m_a = '0; m_b = '0; m_op = '0; m_flags = '0;
        return;
      end
      sin = fr[10 - i];
    end
    // Stop bit is sampled on the coming posedge (cyc + 1); report one later.
    model_frame(is_ctl, d, stop_ok, cyc + 2);
    idle(gap);
  endtask

  task automatic send_pkt(input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic [3:0] crc,
                          input int nbytes, input bit ctl7,
                          input int bad_idx, input int gap);
    logic [63:0] d;
    logic [7:0]  byt;
    d = {b, a};
    for (int i = 0; i < nbytes; i++) begin
      byt = (i < 8) ? d[63 - 8 * i -: 8] : 8'($urandom);
      send_frame(1'b0, byt, (i != bad_idx), gap);
      if (i == bad_idx) return;
    end
    send_frame(1'b1, {ctl7, op, crc}, (bad_idx != nbytes), gap);
  endtask

  task automatic send_good(input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op, input int gap);
    send_pkt(a, b, op, ref_crc({b, a, 1'b1, op}), 8, 1'b0, -1, gap);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_operands"}, {cmd_a, cmd_b}, 64'd0);
    chk({tag, "_ctrl"}, 64'({cmd_valid, cmd_op, err_valid, err_flags}), 64'd0);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  logic [31:0] ra, rb;
  logic [2:0]  rop;
  logic [3:0]  rcrc;
  int          rnb, rbad, rgap;
  bit          rc7;

  initial begin
    rst_n = 1'b0;
    sin   = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(3);

    // Valid ADD, gapless: report 99 cycles after the first start bit.
    send_good(32'h0000_0001, 32'h0000_0002, 3'b100, 0);
    idle(4);

    // SUB with the constant-1 CRC bit replaced by 0 -> CRC error.
    send_pkt(32'hFFFF_FFFF, 32'h8000_0000, 3'b101,
             ref_crc({32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 3'b101}),
             8, 1'b0, -1, 0);
    idle(4);

    // B[7:0] sent as CTL, then A and CTL -> two length errors.
    send_pkt(32'h0, 32'h1122_3344, 3'b100, 4'h4, 3, 1'b0, -1, 0);
    send_frame(1'b0, 8'hAA); send_frame(1'b0, 8'hBB);
    send_frame(1'b0, 8'hCC); send_frame(1'b0, 8'hDD);
    send_frame(1'b1, 8'h45);
    idle(4);

    // Illegal opcode with matching CRC, then a valid AND back-to-back.
    send_good(32'h1357_9BDF, 32'h2468_ACE0, 3'b010, 0);
    send_good(32'hDEAD_BEEF, 32'hCAFE_F00D, 3'b000, 0);
    idle(4);

    // Framing error in byte 5, then a valid packet.
    send_pkt(32'h0, 32'h0, 3'b000, 4'h0, 8, 1'b0, 4, 2);
    send_good(32'hA5A5_0F0F, 32'h5A5A_F0F0, 3'b001, 0);
    idle(4);

    // Reset at bit 4 of byte 6, release, then a valid OR packet.
    for (int i = 0; i < 5; i++) send_frame(1'b0, 8'(8'h10 + i));
    send_frame(1'b0, 8'h77, 1'b1, 0, 4);
    repeat (3) @(negedge clk);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    idle(2);
    send_good(32'h0BAD_F00D, 32'h1234_5678, 3'b001, 1);
    idle(4);

    // Randomized packets.
    for (int p = 0; p < 40; p++) begin
      ra = $urandom; rb = $urandom; rop = 3'($urandom_range(0, 7));
      rgap = $urandom_range(0, 2);
      rcrc = ref_crc({rb, ra, 1'b1, rop});
      rnb = 8; rc7 = 1'b0; rbad = -1;
      case ($urandom_range(0, 7))
        0: rcrc = rcrc ^ 4'($urandom_range(1, 15));
        1: rnb  = $urandom_range(0, 10);
        2: rc7  = 1'b1;
        3: rbad = $urandom_range(0, 8);
        default: ;
      endcase
      send_pkt(ra, rb, rop, rcrc, rnb, rc7, rbad, rgap);
      if (rbad >= 0) idle(1);
    end

    idle(20);
    chk("missing_reports", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_alu_cmd_rx
`default_nettype wire
